// File: rtl/zx_video_pkg.sv
// Shared ZX Spectrum video definitions: screen geometry, colour index layout,
// interrupt states and the display-file / attribute address maps.
package zx_video_pkg;

  localparam int          SCR_W     = 256;
  localparam int          SCR_H     = 192;
  localparam logic [12:0] ATTR_BASE = 13'h1800;

  typedef struct packed {
    logic bright;
    logic g;
    logic r;
    logic b;
  } colour_t;

  typedef enum logic {
    INT_IDLE,
    INT_PULSE
  } int_state_t;

  // The display file interleaves lines: third, line-in-char, char-row, column.
  function automatic logic [12:0] pix_addr(input logic [7:0] sy, input logic [4:0] col);
    return {sy[7:6], sy[2:0], sy[5:3], col};
  endfunction

  function automatic logic [12:0] attr_addr(input logic [7:0] sy, input logic [4:0] col);
    return ATTR_BASE | {3'b000, sy[7:3], col};
  endfunction

endpackage

// File: rtl/zx_screen_fetch_if.sv
// Video RAM read ports B (display file) and C (attributes), both 1-cycle latency.
interface zx_screen_fetch_if;
  logic [12:0] vga_addr;
  logic [7:0]  vga_data;
  logic [12:0] attr_addr;
  logic [7:0]  attr_data;

  modport master (output vga_addr, attr_addr, input vga_data, attr_data);
  modport slave  (input vga_addr, attr_addr, output vga_data, attr_data);
endinterface

// File: rtl/zx_pixel_shifter.sv
// Byte holding registers, 2x-doubled MSB-first shifter and ink/paper/flash/border
// colour selection, with a two-stage output pipeline.
module zx_pixel_shifter
  import zx_video_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cap_en_i,
  input  logic       load_en_i,
  input  logic       in_scr_i,
  input  logic       flash_phase_i,
  input  logic [2:0] border_i,
  input  logic [7:0] vga_data_i,
  input  logic [7:0] attr_data_i,
  output logic [3:0] pix_color_o
);

  logic [7:0] hold_pix_q, hold_pix_d, hold_attr_q, hold_attr_d;
  logic [7:0] shift_q, shift_d, attr_q, attr_d;
  logic       dbl_q, dbl_d;
  logic       ink_sel;
  colour_t    pix_d, pix1_q, pix2_q;

  always_comb begin
    hold_pix_d  = hold_pix_q;
    hold_attr_d = hold_attr_q;
    shift_d     = shift_q;
    attr_d      = attr_q;
    dbl_d       = ~dbl_q;
    if (cap_en_i) begin
      hold_pix_d  = vga_data_i;
      hold_attr_d = attr_data_i;
    end
    // A byte load restarts the doubling phase so each pixel spans exactly two clocks.
    if (load_en_i) begin
      shift_d = hold_pix_q;
      attr_d  = hold_attr_q;
      dbl_d   = 1'b0;
    end else if (dbl_q) begin
      shift_d = {shift_q[6:0], 1'b0};
    end

    ink_sel = shift_q[7] ^ (attr_q[7] & flash_phase_i);
    if (in_scr_i) begin
      pix_d = colour_t'({attr_q[6], ink_sel ? attr_q[2:0] : attr_q[5:3]});
    end else begin
      pix_d = colour_t'({1'b0, border_i});
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_pix_q  <= '0;
      hold_attr_q <= '0;
      shift_q     <= '0;
      attr_q      <= '0;
      dbl_q       <= 1'b0;
      pix1_q      <= '0;
      pix2_q      <= '0;
    end else begin
      hold_pix_q  <= hold_pix_d;
      hold_attr_q <= hold_attr_d;
      shift_q     <= shift_d;
      attr_q      <= attr_d;
      dbl_q       <= dbl_d;
      pix1_q      <= pix_d;
      pix2_q      <= pix1_q;
    end
  end

  assign pix_color_o = pix2_q;

endmodule

// File: rtl/zx_screen_fetch.sv
// Spectrum screen fetch stage: raster-driven RAM addressing, flash frame counter
// and CPU frame interrupt, feeding the pixel serialiser.
module zx_screen_fetch
  import zx_video_pkg::*;
#(
  parameter int X0       = 64,
  parameter int Y0       = 48,
  parameter int INT_LINE = 480,
  parameter int INT_CLKS = 228
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              de,
  input  logic [2:0]        border_color,
  zx_screen_fetch_if.master ram,
  output logic [3:0]        pix_color,
  output logic              pix_de,
  output logic              n_int
);

  localparam logic [7:0] IntLoad = 8'(INT_CLKS - 1);

  logic [10:0] fx_rel, sx_rel, dy_rel;
  logic [7:0]  sy;
  logic [4:0]  kf;
  logic        line_ok, fetch_ok, in_scr, cap_en, load_en, trigger;
  logic [12:0] vga_addr_q, vga_addr_d, attr_addr_q, attr_addr_d;
  logic [4:0]  frame_q, frame_d;
  logic [7:0]  int_cnt_q, int_cnt_d;
  int_state_t  int_state_q, int_state_d;
  logic [1:0]  de_q;

  // Fetch runs one byte (16 clocks) ahead of the pixel being displayed.
  assign fx_rel   = 11'(x) + 11'd16 - 11'(X0);
  assign sx_rel   = 11'(x) - 11'(X0);
  assign dy_rel   = 11'(y) - 11'(Y0);
  assign sy       = dy_rel[8:1];
  assign kf       = fx_rel[8:4];
  assign line_ok  = dy_rel < 11'(2 * SCR_H);
  assign fetch_ok = line_ok && (fx_rel < 11'(2 * SCR_W));
  assign in_scr   = line_ok && (sx_rel < 11'(2 * SCR_W));
  assign cap_en   = fetch_ok && (fx_rel[3:0] == 4'hE);
  assign load_en  = fetch_ok && (fx_rel[3:0] == 4'hF);
  assign trigger  = (x == 10'd0) && (y == 10'(INT_LINE));

  always_comb begin
    vga_addr_d  = vga_addr_q;
    attr_addr_d = attr_addr_q;
    frame_d     = frame_q;
    int_state_d = int_state_q;
    int_cnt_d   = int_cnt_q;
    if (fetch_ok) begin
      vga_addr_d  = pix_addr(sy, kf);
      attr_addr_d = attr_addr(sy, kf);
    end
    if (trigger) begin
      frame_d     = frame_q + 5'd1;
      int_state_d = INT_PULSE;
      int_cnt_d   = IntLoad;
    end else if (int_state_q == INT_PULSE) begin
      if (int_cnt_q == 8'd0) begin
        int_state_d = INT_IDLE;
      end else begin
        int_cnt_d = int_cnt_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vga_addr_q  <= '0;
      attr_addr_q <= '0;
      frame_q     <= '0;
      int_state_q <= INT_IDLE;
      int_cnt_q   <= '0;
      de_q        <= '0;
    end else begin
      vga_addr_q  <= vga_addr_d;
      attr_addr_q <= attr_addr_d;
      frame_q     <= frame_d;
      int_state_q <= int_state_d;
      int_cnt_q   <= int_cnt_d;
      de_q        <= {de_q[0], de};
    end
  end

  assign ram.vga_addr  = vga_addr_q;
  assign ram.attr_addr = attr_addr_q;
  assign pix_de        = de_q[1];
  assign n_int         = (int_state_q != INT_PULSE);

  zx_pixel_shifter u_shifter (
    .clk          (clk),
    .reset_n      (reset_n),
    .cap_en_i     (cap_en),
    .load_en_i    (load_en),
    .in_scr_i     (in_scr),
    .flash_phase_i(frame_q[4]),
    .border_i     (border_color),
    .vga_data_i   (ram.vga_data),
    .attr_data_i  (ram.attr_data),
    .pix_color_o  (pix_color)
  );

endmodule

// File: tb/tb_zx_screen_fetch.sv
// Scoreboard bench for zx_screen_fetch: directed raster vectors push expected
// outputs with their due cycle; a monitor compares them when they fall due.
module tb_zx_screen_fetch;
  import zx_video_pkg::*;

  localparam int X0 = 64, Y0 = 48, INT_LINE = 480, INT_CLKS = 228;

  typedef enum int {K_PIX, K_ADDR, K_INT, K_ALL} kind_t;
  typedef struct {
    int          due;
    kind_t       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0, nChecks = 0, nFails = 0;

  logic       clk = 1'b0, reset_n = 1'b0, de = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic [2:0] border_color = '0;
  logic [3:0] pix_color;
  logic       pix_de, n_int;
  logic [7:0] mem [0:8191];
  logic [3:0] expByte0 [16];
  logic [3:0] expByte1 [16];
  logic [3:0] expByte31 [16];

  zx_screen_fetch_if ram();

  zx_screen_fetch #(.X0(X0), .Y0(Y0), .INT_LINE(INT_LINE), .INT_CLKS(INT_CLKS)) dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .de(de), .border_color(border_color),
    .ram(ram), .pix_color(pix_color), .pix_de(pix_de), .n_int(n_int)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Video RAM model with a registered (1-cycle) read on both ports.
  always @(posedge clk) begin
    ram.vga_data  <= mem[ram.vga_addr];
    ram.attr_data <= mem[ram.attr_addr];
  end

  function automatic logic [31:0] pixVal(input logic [3:0] c, input logic d);
    return {27'd0, c, d};
  endfunction

  function automatic logic [31:0] addrVal(input logic [12:0] va, input logic [12:0] aa);
    return {6'd0, va, aa};
  endfunction

  task automatic pushExp(input kind_t k, input int due, input logic [31:0] v, input string nm);
    exp_t e;
    e.due = due; e.kind = k; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] act;
    case (e.kind)
      K_PIX:   act = {27'd0, pix_color, pix_de};
      K_ADDR:  act = {6'd0, ram.vga_addr, ram.attr_addr};
      K_INT:   act = {31'd0, n_int};
      default: act = {pix_color, pix_de, n_int, ram.vga_addr, ram.attr_addr};
    endcase
    nChecks++;
    if (act !== e.val) begin
      nFails++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", e.name, cyc, act, e.val);
    end
  endtask

  // Monitor: compare every expectation whose due cycle is the current one.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic applyStimulus(input int xi, input int yi, input logic dei, input logic [2:0] bc);
    x = 10'(xi);
    y = 10'(yi);
    de = dei;
    border_color = bc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    logic [3:0] c;
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[13'h0000] = 8'hA5; mem[13'h1800] = 8'h47;
    mem[13'h0001] = 8'h0F; mem[13'h1801] = 8'h0A;
    mem[13'h001F] = 8'h81; mem[13'h181F] = 8'h07;
    mem[13'h0020] = 8'hFF; mem[13'h1820] = 8'hB8;
    // 8'h47 is bright ink 7 on paper 0; bright paper black is colour index 8.
    expByte0  = '{4'hF, 4'hF, 4'h8, 4'h8, 4'hF, 4'hF, 4'h8, 4'h8,
                  4'h8, 4'h8, 4'hF, 4'hF, 4'h8, 4'h8, 4'hF, 4'hF};
    expByte1  = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1,
                  4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2};
    expByte31 = '{4'h7, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7, 4'h7};

    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) pushExp(K_ALL, cyc + 1, {4'h0, 1'b0, 1'b1, 26'd0}, "power-on reset");
      applyStimulus(700, 500, 1'b0, 3'd0);
    end
    reset_n = 1'b1;

    // Address map on sy = 65, including window edges and hold outside the fetch range.
    for (int xx = 96; xx <= 109; xx++) begin
      if (xx == 96 || xx == 100 || xx == 109)
        pushExp(K_ADDR, cyc + 1, addrVal(13'h0903, 13'h1903), $sformatf("addr k=3 x=%0d", xx));
      applyStimulus(xx, 178, 1'b0, 3'd0);
    end
    pushExp(K_ADDR, cyc + 1, addrVal(13'h091C, 13'h191C), "addr k=28");
    applyStimulus(500, 178, 1'b0, 3'd0);
    pushExp(K_ADDR, cyc + 1, addrVal(13'h091F, 13'h191F), "addr k=31 last");
    applyStimulus(559, 178, 1'b0, 3'd0);
    pushExp(K_ADDR, cyc + 1, addrVal(13'h091F, 13'h191F), "addr hold after window");
    applyStimulus(560, 178, 1'b0, 3'd0);

    // Mid-line reset held for four clocks.
    for (int xx = 200; xx < 210; xx++) begin
      if (xx == 205) pushExp(K_PIX, cyc + 2, pixVal(4'h3, 1'b0), "border before reset");
      applyStimulus(xx, 10, 1'b0, 3'd3);
    end
    reset_n = 1'b0;
    for (int xx = 210; xx < 214; xx++) begin
      pushExp(K_ALL, cyc + 1, {4'h0, 1'b0, 1'b1, 26'd0}, $sformatf("mid-line reset x=%0d", xx));
      applyStimulus(xx, 10, 1'b0, 3'd3);
    end
    reset_n = 1'b1;

    // First line of screen: border, byte 0 (A5/47), byte 1 (0F/0A), byte 2 (blank).
    for (int xx = 44; xx <= 104; xx++) begin
      if (xx < X0) c = 4'h3;
      else if (xx < X0 + 16) c = expByte0[xx - X0];
      else if (xx < X0 + 32) c = expByte1[xx - X0 - 16];
      else c = 4'h0;
      pushExp(K_PIX, cyc + 2, pixVal(c, xx >= X0), $sformatf("pixel x=%0d", xx));
      applyStimulus(xx, Y0, xx >= X0, 3'd3);
    end

    // Right edge: byte 30 blank, byte 31 (81/07), then border from X0+512.
    for (int xx = 540; xx <= 580; xx++) begin
      if (xx >= 544) begin
        if (xx < X0 + 496) c = 4'h0;
        else if (xx < X0 + 512) c = expByte31[xx - X0 - 496];
        else c = 4'h3;
        pushExp(K_PIX, cyc + 2, pixVal(c, xx < X0 + 512), $sformatf("right edge x=%0d", xx));
      end
      applyStimulus(xx, Y0, xx < X0 + 512, 3'd3);
    end

    // Border colour change mid-run.
    for (int xx = 10; xx <= 25; xx++) begin
      c = (xx < 20) ? 4'h2 : 4'h5;
      pushExp(K_PIX, cyc + 2, pixVal(c, 1'b0), $sformatf("border x=%0d", xx));
      applyStimulus(xx, 10, 1'b0, (xx < 20) ? 3'b010 : 3'b101);
    end

    // Flash over 33 frames: B8 is flashing ink 0 on paper 7, data all ones.
    for (int f = 0; f <= 32; f++) begin
      for (int xx = 48; xx <= 65; xx++) begin
        if (xx >= 64)
          pushExp(K_PIX, cyc + 2, pixVal((f >= 16 && f < 32) ? 4'h7 : 4'h0, 1'b1),
                  $sformatf("flash frame %0d x=%0d", f, xx));
        applyStimulus(xx, 64, 1'b1, 3'd0);
      end
      applyStimulus(0, INT_LINE, 1'b0, 3'd0);
    end

    // Frame interrupt width.
    for (int i = 0; i < 300; i++) applyStimulus(5, 0, 1'b0, 3'd0);
    t = cyc;
    pushExp(K_INT, t, 32'd1, "n_int before trigger");
    pushExp(K_INT, t + 1, 32'd0, "n_int first low");
    pushExp(K_INT, t + INT_CLKS, 32'd0, "n_int last low");
    pushExp(K_INT, t + INT_CLKS + 1, 32'd1, "n_int released");
    applyStimulus(0, INT_LINE, 1'b0, 3'd0);
    for (int xx = 1; xx <= 300; xx++) applyStimulus(xx, INT_LINE, 1'b0, 3'd0);

    // Reset 50 clocks into a pulse ends it on the next edge.
    applyStimulus(0, INT_LINE, 1'b0, 3'd0);
    for (int xx = 1; xx < 50; xx++) applyStimulus(xx, INT_LINE, 1'b0, 3'd0);
    pushExp(K_INT, cyc, 32'd0, "n_int low before reset");
    pushExp(K_INT, cyc + 1, 32'd1, "n_int cleared by reset");
    reset_n = 1'b0;
    applyStimulus(50, INT_LINE, 1'b0, 3'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(60 + i, INT_LINE, 1'b0, 3'd0);

    foreach (sb[i]) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s: got nothing, expected %h by cycle %0d", sb[i].name, sb[i].val, sb[i].due);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
